wb_board_arbiter: RTL

- Round-robin Wishbone arbiter that shares the single 8-bit board-memory slave (16x16 tile store) between NUM_MASTERS requesters, e.g. game FSM, mine generator, draw/VGA tile reader.
- Sits between the masters' Wishbone master ports and the memory's Wishbone slave port.
- Owns bus ownership, request/response muxing, ACK routing and an optional stuck-slave timeout.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_board_arbiter_if.sv | 39 +++
 rtl/wb_board_arbiter_rr_picker.sv | 31 +++
 rtl/wb_board_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the board-memory Wishbone arbiter.
//   WB_ADDR_W / WB_DATA_W : board-memory bus widths (16x16 tile store, 8-bit data)
//   arb_state_e           : arbiter ownership states
//   WB_TIMEOUT_DATA       : read value returned on a forced (timed-out) termination
package wb_pkg;

   localparam int WB_ADDR_W = 8;
   localparam int WB_DATA_W = 8;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_e;

   localparam logic [WB_DATA_W-1:0] WB_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/wb_board_arbiter_if.sv
// Bundle of the master-side and slave-side Wishbone signals around the arbiter.
//   m_*  : NUM_MASTERS requesters, per-master fields packed master k at [W*k +: W]
//   s_*  : the single board-memory slave
// Modports:
//   slave  : the arbiter's view (it is the slave the masters talk to)
//   master : the surrounding system's view (drives masters' requests and the
//            memory's response, observes the arbitrated bus)
interface wb_board_arbiter_if #(
   parameter int NUM_MASTERS = 3
);
   import wb_pkg::*;

   logic [NUM_MASTERS-1:0]           m_cyc_i;
   logic [NUM_MASTERS-1:0]           m_stb_i;
   logic [NUM_MASTERS-1:0]           m_we_i;
   logic [NUM_MASTERS*WB_ADDR_W-1:0] m_adr_i;
   logic [NUM_MASTERS*WB_DATA_W-1:0] m_dat_i;
   logic [WB_DATA_W-1:0]             m_dat_o;
   logic [NUM_MASTERS-1:0]           m_ack_o;

   logic                             s_cyc_o;
   logic                             s_stb_o;
   logic                             s_we_o;
   logic [WB_ADDR_W-1:0]             s_adr_o;
   logic [WB_DATA_W-1:0]             s_dat_o;
   logic [WB_DATA_W-1:0]             s_dat_i;
   logic                             s_ack_i;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
      output m_dat_o, m_ack_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
      input  m_dat_o, m_ack_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
   );

endinterface

// File: rtl/wb_board_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req_i : request vector
//   ptr_i : index of the highest-priority requester
//   gnt_o : one-hot grant of the first requester at or after ptr_i (cyclic),
//           all-zero when nothing is requested
module rr_picker #(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   always_comb begin
      int  idx;
      logic found;
      gnt_o = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_board_arbiter.sv
// Round-robin Wishbone arbiter sharing the board-memory slave between
// NUM_MASTERS requesters (game FSM, mine generator, tile reader, ...).
// Ports:
//   CLK_I      system clock, rising edge
//   RST_I      asynchronous active-high reset
//   bus        wb_board_arbiter_if.slave: master requests in, slave request
//              out, slave response in, routed ACK / read data out
//   grant_o    one-hot current owner, zero when idle
//   busy_o     a master owns the bus
//   timeout_o  sticky forced-termination flag (0 unless WB_ARB_TIMEOUT_EN)
// Build option: define WB_ARB_TIMEOUT_EN to add the stuck-slave timeout.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no owner; first cyclic requester from the pointer is granted
// ST_OWNED  | grant_q owner holds the bus while its CYC stays high; on
//           | release the next requester is granted on the same edge
module wb_board_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_MASTERS    = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                   CLK_I,
   input  logic                   RST_I,
   wb_board_arbiter_if.slave      bus,
   output logic [NUM_MASTERS-1:0] grant_o,
   output logic                   busy_o,
   output logic                   timeout_o
);

   localparam int PW = $clog2(NUM_MASTERS);

   localparam logic [0:0] ST_IDLE  = ARB_IDLE;
   localparam logic [0:0] ST_OWNED = ARB_OWNED;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_masters
      $error("wb_board_arbiter: NUM_MASTERS must be 2..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("wb_board_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   logic [0:0]             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]          ptr_q, ptr_d;

   logic [PW-1:0]          owner_idx;
   logic [PW-1:0]          ptr_rel;
   logic [PW-1:0]          pick_ptr;
   logic [NUM_MASTERS-1:0] pick_gnt;
   logic                   owner_cyc;
   logic                   slv_ack;

   always_comb begin
      owner_idx = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (grant_q[k]) owner_idx = PW'(k);
      end
   end

   assign owner_cyc = |(bus.m_cyc_i & grant_q);
   assign ptr_rel   = (owner_idx == PW'(NUM_MASTERS - 1)) ? '0 : owner_idx + 1'b1;

   // On a release the new pointer already applies to the same-edge handover.
   assign pick_ptr  = (state_q == ST_OWNED) ? ptr_rel : ptr_q;

   rr_picker #(.N(NUM_MASTERS), .PW(PW)) u_picker (
      .req_i (bus.m_cyc_i & ~grant_q),
      .ptr_i (pick_ptr),
      .gnt_o (pick_gnt)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (|bus.m_cyc_i) begin
               grant_d = pick_gnt;
               state_d = ST_OWNED;
            end
         end
         default: begin
            if (!owner_cyc) begin
               ptr_d   = ptr_rel;
               grant_d = pick_gnt;
               state_d = (|pick_gnt) ? ST_OWNED : ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant_o = grant_q;
   assign busy_o  = (state_q == ST_OWNED);

   always_comb begin
      bus.s_adr_o = '0;
      bus.s_dat_o = '0;
      bus.s_we_o  = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (grant_q[k]) begin
            bus.s_adr_o = bus.m_adr_i[k*WB_ADDR_W +: WB_ADDR_W];
            bus.s_dat_o = bus.m_dat_i[k*WB_DATA_W +: WB_DATA_W];
            bus.s_we_o  = bus.m_we_i[k];
         end
      end
   end

   assign bus.s_cyc_o = owner_cyc & busy_o;
   // STB is qualified by CYC, so a master strobing without CYC never reaches
   // the slave and a late ACK after release finds STB already low.
   assign bus.s_stb_o = (|(bus.m_stb_i & grant_q)) & bus.s_cyc_o;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] to_cnt_q, to_cnt_d;
   logic          to_flag_q;
   logic          to_fire;

   // Down-counter reloaded whenever the strobe is acknowledged or dropped;
   // reaching zero with STB still pending forces the termination beat.
   assign to_fire = bus.s_stb_o && (to_cnt_q == '0);

   always_comb begin
      to_cnt_d = CW'(TIMEOUT_CYCLES);
      if (bus.s_stb_o && !bus.s_ack_i && !to_fire) to_cnt_d = to_cnt_q - 1'b1;
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         to_cnt_q  <= CW'(TIMEOUT_CYCLES);
         to_flag_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         to_flag_q <= to_flag_q | to_fire;
      end
   end

   assign slv_ack     = (bus.s_ack_i & bus.s_stb_o & ~to_fire) | to_fire;
   assign bus.m_dat_o = to_fire ? WB_TIMEOUT_DATA : bus.s_dat_i;
   assign timeout_o   = to_flag_q;
`else
   assign slv_ack     = bus.s_ack_i & bus.s_stb_o;
   assign bus.m_dat_o = bus.s_dat_i;
   assign timeout_o   = 1'b0;
`endif

   assign bus.m_ack_o = grant_q & {NUM_MASTERS{slv_ack}};

endmodule
